md_unit_param: RTL and testbench
================================

// Module: md_unit_param
// PURPOSE
//  Parametrised multicycle multiply/divide unit with HI/LO registers for the MIPS core's E stage.
//  - Takes a pre-decoded op and start pulse, not the raw instruction word.
//  - Adds MADD/MADDU/MSUB/MSUBU accumulate modes, a divide-by-zero flag, a done pulse and flush (abort).
//  - Latencies are configurable; the core stalls MD instructions while busy is high.
// PARAMETERS
//  WIDTH        32  operand width and HI/LO width; product is 2*WIDTH
//  MULT_CYCLES   5  busy cycles for MULT/MULTU/MADD*/MSUB* (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      asynchronous, active-low reset
//  start     in   1      launch md_op this cycle
//  md_op     in   3      0 MULT,1 MULTU,2 DIV,3 DIVU,4 MADD,5 MADDU,6 MSUB,7 MSUBU
//  src_a     in   WIDTH  rs operand
//  src_b     in   WIDTH  rt operand
//  mt_hi     in   1      write src_a to HI (MTHI)
//  mt_lo     in   1      write src_a to LO (MTLO)
//  flush     in   1      abort in-flight op (exception/eret)
//  busy      out  1      op in flight
//  done      out  1      one-cycle pulse after commit
//  div_zero  out  1      last completed DIV/DIVU had src_b==0
//  hi        out  WIDTH  HI register (MFHI)
//  lo        out  WIDTH  LO register (MFLO)
// BEHAVIOUR
//  - reset low (async): hi=lo=0, busy=0, done=0, div_zero=0, counter=0, captured operands=0.
//  - Priority per edge: flush > start > mt_hi/mt_lo.
//  - Accept: start=1, busy=0, flush=0 at edge E0.
//    - Latch op, src_a, src_b; load counter with N = MULT_CYCLES or DIV_CYCLES.
//    - busy=1 after E0; div_zero cleared at E0.
//  - Each edge while busy: counter-1. At edge E0+N: commit hi/lo, busy=0, done=1 for exactly one cycle.
//    Back-to-back start is legal in the done cycle.
//  - start while busy: ignored entirely; the core must hold it.
//  - mt_hi/mt_lo: only when busy=0 and start=0; write hi/lo at that edge. Both set: both written with src_a.
//    Ignored while busy or when start is present.
//  - Arithmetic (all results 2*WIDTH, wrap-around, no overflow flags):
//    - MULT: signed a*b. MULTU: unsigned a*b. {hi,lo} <= product.
//    - MADD/MADDU: {hi,lo} <= {hi,lo} + product (signed/unsigned). MSUB/MSUBU: {hi,lo} - product.
//    - Accumulate uses hi/lo at commit, which are unchanged since accept.
//    - DIV: lo=a/b truncating toward zero; hi=a%b with the sign of a. DIVU: unsigned.
//    - DIV with a = -2^(WIDTH-1), b = -1: lo = -2^(WIDTH-1), hi = 0.
//    - DIV/DIVU with b=0: full DIV_CYCLES latency, hi/lo unchanged, div_zero=1 at commit, done pulses.
//  - flush while busy: counter=0, busy=0 next edge; no commit, no done; hi/lo and div_zero unchanged.
//    flush with start in the same cycle: start dropped.
//  - reset mid-op: everything returns to reset values immediately; no commit.
//  - States: IDLE (counter=0) -> RUN (counter>0) -> IDLE via commit or flush.
//  - Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
//  - hi/lo outputs are registers; MF reads during busy return pre-op values (core stalls them).
// TESTING
//  1. MULT a=-3 (FFFFFFFD), b=5 -> busy high 5 cycles; hi=FFFFFFFF, lo=FFFFFFF1; done 1 cycle at E0+5.
//  2. MTHI 0, MTLO 10, then MADDU a=FFFFFFFF, b=2
//     -> {hi,lo}=0x00000002_00000008 (wrap check); MSUB a=1, b=9 after that -> lo decreases by 9.
//  3. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0 after 10 cycles.
//     DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//  4. DIVU a=7, b=0 with hi=lo=0x1234 -> after 10 cycles: div_zero=1, hi/lo=0x1234, done pulses.
//     Next accepted start clears div_zero.
//  5. DIV started, flush at 3rd busy cycle, start MULT held in the same cycle
//     -> busy=0 next cycle, no done, hi/lo unchanged, MULT not launched.
//     Second start while busy -> ignored; first result only.
//  6. reset low at 4th busy cycle of MULTU -> hi=lo=0, busy=0 asynchronously.
//     Parameter sweep WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3 repeats tests 1 and 3.

Source files
------------

// File: rtl/md_unit_param.sv
// md_unit_param: multicycle multiply/divide unit with HI/LO registers for the E stage.
// Ops are launched by a start pulse with a pre-decoded md_op. busy stays high for the
// configured latency, then HI/LO commit and done pulses for one cycle.
// Ports:
//   clk, reset (async, active-low)
//   start, md_op[2:0], src_a, src_b  - launch an op (ignored while busy)
//   mt_hi, mt_lo                     - write src_a into HI/LO when idle and no start
//   flush                            - abort the in-flight op, highest priority
//   busy, done, div_zero             - status
//   hi, lo                           - architectural HI/LO registers
module md_unit_param #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam int unsigned ProdW     = 2 * WIDTH;

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
    logic             done_q, div_zero_q;

    logic             op_unsigned, op_div, div_by_zero, a_neg, b_neg;
    logic [ProdW-1:0] a_ext, b_ext, prod, acc, result;
    logic [WIDTH-1:0] a_mag, b_mag, b_safe, quo_mag, rem_mag, quo, rem;

    // Result datapath works on the captured operands; it is only consumed at commit.
    always_comb begin
        op_unsigned = op_q[0];
        op_div      = (op_q[2:1] == 2'b01);
        // Extending to 2*WIDTH then taking the low half of the product gives the
        // correct signed or unsigned product modulo 2^(2*WIDTH).
        a_ext       = {{WIDTH{~op_unsigned & a_q[WIDTH-1]}}, a_q};
        b_ext       = {{WIDTH{~op_unsigned & b_q[WIDTH-1]}}, b_q};
        prod        = a_ext * b_ext;
        acc         = {hi_q, lo_q};

        // Signed divide via magnitudes; -2^(W-1) / -1 wraps back to -2^(W-1), rem 0.
        a_neg       = ~op_unsigned & a_q[WIDTH-1];
        b_neg       = ~op_unsigned & b_q[WIDTH-1];
        a_mag       = a_neg ? (~a_q + WIDTH'(1)) : a_q;
        b_mag       = b_neg ? (~b_q + WIDTH'(1)) : b_q;
        b_safe      = (b_q == '0) ? WIDTH'(1) : b_mag;
        quo_mag     = a_mag / b_safe;
        rem_mag     = a_mag % b_safe;
        quo         = (a_neg ^ b_neg) ? (~quo_mag + WIDTH'(1)) : quo_mag;
        rem         = a_neg ? (~rem_mag + WIDTH'(1)) : rem_mag;
        div_by_zero = op_div & (b_q == '0);

        case (op_q[2:1])
            2'b00:   result = prod;
            2'b01:   result = {rem, quo};
            2'b10:   result = acc + prod;
            default: result = acc - prod;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                // Abort: nothing commits, and a coincident start or MT is dropped.
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    StRun: begin
                        if (cnt_q == CntW'(1)) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                            if (div_by_zero) begin
                                div_zero_q <= 1'b1;
                            end else begin
                                hi_q <= result[ProdW-1:WIDTH];
                                lo_q <= result[WIDTH-1:0];
                            end
                        end else begin
                            cnt_q <= cnt_q - CntW'(1);
                        end
                    end
                    StIdle: begin
                        if (start) begin
                            state_q    <= StRun;
                            op_q       <= md_op;
                            a_q        <= src_a;
                            b_q        <= src_b;
                            div_zero_q <= 1'b0;
                            cnt_q      <= (md_op[2:1] == 2'b01) ? CntW'(DIV_CYCLES)
                                                                : CntW'(MULT_CYCLES);
                        end else begin
                            if (mt_hi) hi_q <= src_a;
                            if (mt_lo) lo_q <= src_a;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit_param.sv
// Bench for md_unit_param: a 32-bit default instance plus a WIDTH=16, MULT_CYCLES=1,
// DIV_CYCLES=3 instance sharing the same stimulus (low 16 bits of the operands).
module tb_md_unit_param;
    logic        clk = 1'b0;
    logic        reset, start, mt_hi, mt_lo, flush;
    logic [2:0]  md_op;
    logic [31:0] src_a, src_b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    logic        busy16, done16, dz16;
    logic [15:0] hi16, lo16;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    md_unit_param u_dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .src_a(src_a), .src_b(src_b),
        .mt_hi(mt_hi), .mt_lo(mt_lo), .flush(flush), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    md_unit_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut16 (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .src_a(src_a[15:0]),
        .src_b(src_b[15:0]), .mt_hi(mt_hi), .mt_lo(mt_lo), .flush(flush), .busy(busy16),
        .done(done16), .div_zero(dz16), .hi(hi16), .lo(lo16)
    );

    // Reference for the multiply/accumulate ops on the 32-bit instance.
    function automatic logic [63:0] mul_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] acc);
        longint      sp;
        logic [63:0] p;
        if (op[0]) begin
            p = {32'h0, a} * {32'h0, b};
        end else begin
            sp = longint'($signed(a)) * longint'($signed(b));
            p  = sp;
        end
        case (op[2:1])
            2'b10:   return acc + p;
            2'b11:   return acc - p;
            default: return p;
        endcase
    endfunction

    // Tasks below are entered and left at posedge + 1.
    task automatic wait_idle();
        for (int n = 0; n < 100 && (busy || busy16); n++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input bit narrow, output int cycles, output bit timeout);
        cycles  = 0;
        timeout = 1'b0;
        for (int n = 0; !(narrow ? done16 : done); n++) begin
            if (n > 200) begin
                timeout = 1'b1;
                break;
            end
            if (narrow ? busy16 : busy) cycles++;
            @(posedge clk); #1;
        end
    endtask

    task automatic launch(input bit narrow, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cycles, output bit timeout);
        wait_idle();
        start = 1'b1; md_op = op; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(narrow, cycles, timeout);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; flush = 1'b0;
        md_op = 3'd0; src_a = '0; src_b = '0;
        #12;
        vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin
            miscompares++; $display("FAIL reset_hilo: got %h_%h want 0_0", hi, lo);
        end
        vectors++; if ({busy, done, div_zero} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_zero});
        end
        vectors++; if ({busy16, done16, dz16, hi16, lo16} !== 35'h0) begin
            miscompares++; $display("FAIL reset_w16: got %b %h %h want 0", {busy16, done16, dz16},
                                    hi16, lo16);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        vec_t tbl[3];
        exp_t e;
        int   cyc;
        bit   to;
        tbl[0] = {3'd0, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[1] = {3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[2] = {3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        for (int i = 0; i < 3; i++) begin
            sb.push_back({tbl[i].hi, tbl[i].lo, 1'b0});
            launch(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, cyc, to);
            e = sb.pop_front();
            vectors++; if (to || cyc != 5) begin
                miscompares++; $display("FAIL mult_busy[%0d]: got %0d cycles (timeout %0b) want 5",
                                        i, cyc, to);
            end
            vectors++; if (hi !== e.hi || lo !== e.lo) begin
                miscompares++; $display("FAIL mult_result[%0d]: got %h_%h want %h_%h", i, hi, lo,
                                        e.hi, e.lo);
            end
            @(posedge clk); #1;
            vectors++; if (done !== 1'b0) begin
                miscompares++; $display("FAIL mult_done_pulse[%0d]: got %b want 0", i, done);
            end
        end
    endtask

    task automatic test_madd_msub();
        logic [2:0]  ops[4] = '{3'd5, 3'd6, 3'd4, 3'd7};
        logic [31:0] as[4]  = '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] bs[4]  = '{32'h2, 32'h9, 32'h3, 32'h1};
        logic [63:0] acc;
        exp_t        e;
        int          cyc;
        bit          to;
        mt_hi = 1'b1; src_a = 32'h0;
        @(posedge clk); #1;
        mt_hi = 1'b0; mt_lo = 1'b1; src_a = 32'd10;
        @(posedge clk); #1;
        mt_lo = 1'b0;
        vectors++; if (hi !== 32'h0 || lo !== 32'd10) begin
            miscompares++; $display("FAIL mt_write: got %h_%h want 0_a", hi, lo);
        end
        acc = 64'd10;
        for (int i = 0; i < 4; i++) begin
            acc = mul_model(ops[i], as[i], bs[i], acc);
            sb.push_back({acc, 1'b0});
            launch(1'b0, ops[i], as[i], bs[i], cyc, to);
            e = sb.pop_front();
            vectors++; if (to || cyc != 5) begin
                miscompares++; $display("FAIL acc_busy[%0d]: got %0d cycles (timeout %0b) want 5",
                                        i, cyc, to);
            end
            vectors++; if (hi !== e.hi || lo !== e.lo) begin
                miscompares++; $display("FAIL acc_result[%0d]: got %h_%h want %h_%h", i, hi, lo,
                                        e.hi, e.lo);
            end
        end
    endtask

    task automatic test_div();
        vec_t tbl[5];
        exp_t e;
        int   cyc;
        bit   to;
        tbl[0] = {3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[1] = {3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[2] = {3'd3, 32'd100, 32'd7, 32'd2, 32'd14};
        tbl[3] = {3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
        tbl[4] = {3'd3, 32'hFFFFFFF9, 32'h2, 32'd1, 32'h7FFFFFFC};
        for (int i = 0; i < 5; i++) begin
            sb.push_back({tbl[i].hi, tbl[i].lo, 1'b0});
            launch(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, cyc, to);
            e = sb.pop_front();
            vectors++; if (to || cyc != 10) begin
                miscompares++; $display("FAIL div_busy[%0d]: got %0d cycles (timeout %0b) want 10",
                                        i, cyc, to);
            end
            vectors++; if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
                miscompares++; $display("FAIL div_result[%0d]: got %h_%h dz %b want %h_%h dz %b",
                                        i, hi, lo, div_zero, e.hi, e.lo, e.dz);
            end
        end
    endtask

    task automatic test_div_zero();
        exp_t e;
        int   cyc;
        bit   to;
        mt_hi = 1'b1; mt_lo = 1'b1; src_a = 32'h1234;
        @(posedge clk); #1;
        mt_hi = 1'b0; mt_lo = 1'b0;
        vectors++; if (hi !== 32'h1234 || lo !== 32'h1234) begin
            miscompares++; $display("FAIL mt_both: got %h_%h want 1234_1234", hi, lo);
        end
        sb.push_back({32'h1234, 32'h1234, 1'b1});
        launch(1'b0, 3'd3, 32'd7, 32'd0, cyc, to);
        e = sb.pop_front();
        vectors++; if (to || cyc != 10) begin
            miscompares++; $display("FAIL dz_busy: got %0d cycles (timeout %0b) want 10", cyc, to);
        end
        vectors++; if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
            miscompares++; $display("FAIL dz_result: got %h_%h dz %b want %h_%h dz %b", hi, lo,
                                    div_zero, e.hi, e.lo, e.dz);
        end
        sb.push_back({32'h0, 32'h6, 1'b0});
        wait_idle();
        start = 1'b1; md_op = 3'd1; src_a = 32'd2; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++; if (div_zero !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL dz_clear: got dz %b busy %b want dz 0 busy 1",
                                    div_zero, busy);
        end
        wait_done(1'b0, cyc, to);
        e = sb.pop_front();
        vectors++; if (to || hi !== e.hi || lo !== e.lo) begin
            miscompares++; $display("FAIL dz_next_op: got %h_%h (timeout %0b) want %h_%h", hi, lo,
                                    to, e.hi, e.lo);
        end
    endtask

    task automatic test_flush();
        bit   saw;
        exp_t e;
        int   cyc;
        bit   to;
        wait_idle();
        start = 1'b1; md_op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;               // 1st busy cycle
        start = 1'b0;
        @(posedge clk); #1;               // 2nd
        @(posedge clk); #1;               // 3rd: flush with a MULT start held
        flush = 1'b1; start = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL flush_stop: got busy %b done %b want 0 0", busy, done);
        end
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) saw = 1'b1;
        end
        vectors++; if (saw !== 1'b0) begin
            miscompares++; $display("FAIL flush_quiet: got activity %b want 0", saw);
        end
        vectors++; if (hi !== 32'h0 || lo !== 32'h6) begin
            miscompares++; $display("FAIL flush_hilo: got %h_%h want 0_6", hi, lo);
        end
        // Idle flush with start: start is dropped.
        flush = 1'b1; start = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        vectors++; if (busy !== 1'b0) begin
            miscompares++; $display("FAIL flush_start_idle: got busy %b want 0", busy);
        end
        // Start held while busy is ignored; only the first op commits.
        sb.push_back({32'h0, 32'h23, 1'b0});
        start = 1'b1; md_op = 3'd0; src_a = 32'd5; src_b = 32'd7;
        @(posedge clk); #1;
        md_op = 3'd1; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, cyc, to);
        e = sb.pop_front();
        vectors++; if (to || hi !== e.hi || lo !== e.lo) begin
            miscompares++; $display("FAIL start_while_busy: got %h_%h (timeout %0b) want %h_%h",
                                    hi, lo, to, e.hi, e.lo);
        end
        saw = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (busy || done) saw = 1'b1;
        end
        vectors++; if (saw !== 1'b0) begin
            miscompares++; $display("FAIL start_while_busy_relaunch: got %b want 0", saw);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        bit   to;
        sb.push_back({32'h0, 32'hC, 1'b0});
        sb.push_back({32'h0, 32'h4, 1'b0});
        for (int i = 0; i < 2; i++) begin
            // Second launch starts in the done cycle of the first.
            launch(1'b0, 3'd0, (i == 0) ? 32'd3 : 32'hFFFFFFFE, (i == 0) ? 32'd4 : 32'hFFFFFFFE,
                   cyc, to);
            e = sb.pop_front();
            vectors++; if (to || cyc != 5 || hi !== e.hi || lo !== e.lo) begin
                miscompares++; $display("FAIL b2b[%0d]: got %h_%h %0d cycles (timeout %0b) want %h_%h 5",
                                        i, hi, lo, cyc, to, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_sweep16();
        vec_t tbl[3];
        exp_t e;
        int   cyc;
        bit   to;
        int   want;
        tbl[0] = {3'd0, 32'h0000FFFD, 32'h5, 32'hFFFF, 32'hFFF1};
        tbl[1] = {3'd2, 32'h00008000, 32'h0000FFFF, 32'h0000, 32'h8000};
        tbl[2] = {3'd2, 32'h0000FFF9, 32'h2, 32'hFFFF, 32'hFFFD};
        for (int i = 0; i < 3; i++) begin
            want = (i == 0) ? 1 : 3;
            sb.push_back({tbl[i].hi, tbl[i].lo, 1'b0});
            launch(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, cyc, to);
            e = sb.pop_front();
            vectors++; if (to || cyc != want) begin
                miscompares++; $display("FAIL w16_busy[%0d]: got %0d cycles (timeout %0b) want %0d",
                                        i, cyc, to, want);
            end
            vectors++; if (hi16 !== e.hi[15:0] || lo16 !== e.lo[15:0]) begin
                miscompares++; $display("FAIL w16_result[%0d]: got %h_%h want %h_%h", i, hi16, lo16,
                                        e.hi[15:0], e.lo[15:0]);
            end
            @(posedge clk); #1;
            vectors++; if (done16 !== 1'b0) begin
                miscompares++; $display("FAIL w16_done_pulse[%0d]: got %b want 0", i, done16);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        bit saw;
        wait_idle();
        start = 1'b1; md_op = 3'd1; src_a = 32'hFFFFFFFF; src_b = 32'd2;
        @(posedge clk); #1;               // 1st busy cycle
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;           // ends in the 4th busy cycle
        end
        #2 reset = 1'b0;
        #1;
        vectors++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_op: got %h_%h busy %b done %b want 0_0 0 0",
                                    hi, lo, busy, done);
        end
        vectors++; if (hi16 !== 16'h0 || lo16 !== 16'h0 || busy16 !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_op_w16: got %h_%h busy %b want 0_0 0",
                                    hi16, lo16, busy16);
        end
        @(negedge clk) reset = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy || hi !== 32'h0 || lo !== 32'h0) saw = 1'b1;
        end
        vectors++; if (saw !== 1'b0) begin
            miscompares++; $display("FAIL reset_no_commit: got activity %b want 0", saw);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_madd_msub();
        test_div();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_sweep16();
        test_reset_mid_op();
        vectors++; if (sb.size() != 0) begin
            miscompares++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
